// File: rtl/spi_attn_pkg.sv
// Shared types and width helpers for the attenuator SPI master.
// SPI_ATTN_READBACK_EN (optional) adds MISO capture in the top level.
package spi_attn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int bitcnt_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

    function automatic int cssel_w(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_attn_clkgen.sv
// SCLK generator: half-period counter plus SCLK register, with one-cycle
// leading/trailing edge strobes aligned to the clk edge that moves SCLK.
module spi_attn_clkgen
    import spi_attn_pkg::*;
#(
    parameter int CLK_DIV = 20,
    parameter bit CPOL    = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic en,
    input  logic toggle_en,
    output logic tick,
    output logic lead_edge,
    output logic trail_edge,
    output logic sclk
);

    localparam int CW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV);

    logic [CW-1:0] cnt_reg;
    logic          sclk_reg;

    // tick marks the last cycle of each half-period
    assign tick       = en && (cnt_reg == CNT_MAX);
    assign lead_edge  = tick && toggle_en && (sclk_reg == CPOL);
    assign trail_edge = tick && toggle_en && (sclk_reg != CPOL);
    assign sclk       = sclk_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg  <= '0;
            sclk_reg <= CPOL;
        end else if (!en) begin
            cnt_reg  <= '0;
            sclk_reg <= CPOL;
        end else begin
            cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
            if (tick && toggle_en) begin
                sclk_reg <= ~sclk_reg;
            end
        end
    end

endmodule

// File: rtl/spi_attn_master.sv
// Multi-select SPI master for attenuators: one word per transfer, valid/ready in, done/err out.
// Define SPI_ATTN_READBACK_EN to add spi_miso capture and the rx_data output.
module spi_attn_master
    import spi_attn_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_CS    = 4,
    parameter int CLK_DIV   = 20,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b0,
    localparam int BITCNT_W = bitcnt_w(DATA_W),
    localparam int CSSEL_W  = cssel_w(NUM_CS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic [BITCNT_W-1:0] tx_bits,
    input  logic [CSSEL_W-1:0]  tx_cs_sel,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                done,
    output logic                err,
    output logic                spi_sclk,
    output logic                spi_mosi,
    output logic [NUM_CS-1:0]   spi_cs_n
`ifdef SPI_ATTN_READBACK_EN
    ,
    input  logic                spi_miso,
    output logic [DATA_W-1:0]   rx_data
`endif
);

    localparam int EDGE_W = BITCNT_W + 1;
    localparam logic [1:0] MODE = {CPOL, CPHA};
    localparam bit SAMPLE_ON_TRAIL = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);
    localparam logic [BITCNT_W-1:0] FULL_BITS = BITCNT_W'(DATA_W);

    state_t              state_reg;
    logic                start_reg;
    logic                tx_ready_reg;
    logic                done_reg;
    logic                err_reg;
    logic                mosi_reg;
    logic [NUM_CS-1:0]   cs_n_reg;
    logic [DATA_W-1:0]   data_sh_reg;
    logic [BITCNT_W-1:0] nbits_reg;
    logic [CSSEL_W-1:0]  sel_reg;
    logic [EDGE_W-1:0]   edge_cnt_reg;

    logic                tick;
    logic                lead_edge;
    logic                trail_edge;
    logic                last_edge;
    logic                present_edge;
    logic                sel_bad;
    logic                accept;
    logic                next_bit;
    logic [DATA_W-1:0]   data_shifted;
    logic [BITCNT_W-1:0] norm_bits;
    logic [DATA_W-1:0]   load_word;
    logic [NUM_CS-1:0]   cs_hit;

    spi_attn_clkgen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_clkgen (
        .clk        (clk),
        .srst       (rst),
        .en         ((state_reg != IDLE) && !start_reg),
        .toggle_en  (state_reg == SHIFT),
        .tick       (tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .sclk       (spi_sclk)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
            assign cs_hit[gi] = (sel_reg == CSSEL_W'(gi));
        end
    endgenerate

    // MSB-first words are left-aligned at accept so the outgoing bit is always the top bit
    always_comb begin
        norm_bits = tx_bits;
        if (tx_bits == '0 || tx_bits > FULL_BITS) begin
            norm_bits = FULL_BITS;
        end
        load_word = tx_data;
        if (MSB_FIRST) begin
            load_word = tx_data << (FULL_BITS - norm_bits);
        end
    end

    assign sel_bad      = ({1'b0, tx_cs_sel} >= (CSSEL_W + 1)'(NUM_CS));
    assign accept       = (state_reg == IDLE) && tx_valid && tx_ready_reg && !sel_bad;
    assign next_bit     = MSB_FIRST ? data_sh_reg[DATA_W-1] : data_sh_reg[0];
    assign data_shifted = MSB_FIRST ? (data_sh_reg << 1) : (data_sh_reg >> 1);
    assign last_edge    = (edge_cnt_reg == ({nbits_reg, 1'b0} - EDGE_W'(1)));
    // With CPHA=0 the first bit goes out in SETUP, so the final trailing edge must not advance MOSI
    assign present_edge = SAMPLE_ON_TRAIL ? lead_edge : (trail_edge && !last_edge);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            start_reg    <= 1'b0;
            tx_ready_reg <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            mosi_reg     <= 1'b0;
            cs_n_reg     <= '1;
            data_sh_reg  <= '0;
            nbits_reg    <= '0;
            sel_reg      <= '0;
            edge_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (tx_valid && tx_ready_reg) begin
                        if (sel_bad) begin
                            err_reg <= 1'b1;
                        end else begin
                            data_sh_reg  <= load_word;
                            nbits_reg    <= norm_bits;
                            sel_reg      <= tx_cs_sel;
                            edge_cnt_reg <= '0;
                            tx_ready_reg <= 1'b0;
                            start_reg    <= 1'b1;
                            state_reg    <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (start_reg) begin
                        start_reg <= 1'b0;
                        cs_n_reg  <= ~cs_hit;
                        if (!SAMPLE_ON_TRAIL) begin
                            mosi_reg    <= next_bit;
                            data_sh_reg <= data_shifted;
                        end
                    end else if (tick) begin
                        edge_cnt_reg <= '0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (lead_edge || trail_edge) begin
                        edge_cnt_reg <= edge_cnt_reg + EDGE_W'(1);
                        if (present_edge) begin
                            mosi_reg    <= next_bit;
                            data_sh_reg <= data_shifted;
                        end
                        if (last_edge) begin
                            state_reg <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_n_reg  <= '1;
                        done_reg  <= 1'b1;
                        mosi_reg  <= 1'b0;
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        tx_ready_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef SPI_ATTN_READBACK_EN
    logic              sample_edge;
    logic [DATA_W-1:0] rx_sh_reg;
    logic [DATA_W-1:0] rx_data_reg;

    assign sample_edge = SAMPLE_ON_TRAIL ? trail_edge : lead_edge;

    // LSB-first capture fills from the top, so it is right-aligned when published
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sh_reg   <= '0;
            rx_data_reg <= '0;
        end else begin
            if (accept) begin
                rx_sh_reg <= '0;
            end else if (state_reg == SHIFT && sample_edge) begin
                rx_sh_reg <= MSB_FIRST ? {rx_sh_reg[DATA_W-2:0], spi_miso}
                                       : {spi_miso, rx_sh_reg[DATA_W-1:1]};
            end
            if (state_reg == HOLD && tick) begin
                rx_data_reg <= MSB_FIRST ? rx_sh_reg : (rx_sh_reg >> (FULL_BITS - nbits_reg));
            end
        end
    end

    assign rx_data = rx_data_reg;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

    assign tx_ready = tx_ready_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign spi_mosi = mosi_reg;
    assign spi_cs_n = cs_n_reg;

endmodule

// File: tb/tb_spi_attn_master.sv
// Bench for spi_attn_master: a mode-0 MSB-first and a mode-3 LSB-first instance share stimulus.
// With SPI_ATTN_READBACK_EN each instance loops MOSI back to MISO and rx_data is checked.
module tb_spi_attn_master;
    import spi_attn_pkg::*;

    localparam int DW    = 32;
    localparam int NCS   = 3;
    localparam int DIV   = 1;
    localparam int H     = DIV + 1;
    localparam int LIMIT = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tx_data = '0;
    logic [5:0]  tx_bits = '0;
    logic [1:0]  tx_cs_sel = '0;
    logic        tx_valid = 1'b0;

    logic       ready0, done0, err0, sclk0, mosi0;
    logic       ready3, done3, err3, sclk3, mosi3;
    logic [2:0] csn0, csn3;
`ifdef SPI_ATTN_READBACK_EN
    logic [31:0] rx0, rx3;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] m_cap0, m_cap3;
    int m_edges0, m_edges3, m_low, m_done_k, m_ready_k, m_done_cnt;
    bit m_stray;

    always #5 clk = ~clk;

    spi_attn_master #(
        .DATA_W(DW), .NUM_CS(NCS), .CLK_DIV(DIV),
        .CPOL(SPI_MODE0[1]), .CPHA(SPI_MODE0[0]), .MSB_FIRST(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_bits(tx_bits),
        .tx_cs_sel(tx_cs_sel), .tx_valid(tx_valid), .tx_ready(ready0),
        .done(done0), .err(err0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_cs_n(csn0)
`ifdef SPI_ATTN_READBACK_EN
        , .spi_miso(mosi0), .rx_data(rx0)
`endif
    );

    spi_attn_master #(
        .DATA_W(DW), .NUM_CS(NCS), .CLK_DIV(DIV),
        .CPOL(SPI_MODE3[1]), .CPHA(SPI_MODE3[0]), .MSB_FIRST(1'b0)
    ) dut3 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_bits(tx_bits),
        .tx_cs_sel(tx_cs_sel), .tx_valid(tx_valid), .tx_ready(ready3),
        .done(done3), .err(err3), .spi_sclk(sclk3), .spi_mosi(mosi3), .spi_cs_n(csn3)
`ifdef SPI_ATTN_READBACK_EN
        , .spi_miso(mosi3), .rx_data(rx3)
`endif
    );

    // Reference model: effective length and the word a slave should assemble
    function automatic int norm_len(input logic [5:0] b);
        return (b == 6'd0 || b > 6'd32) ? 32 : int'(b);
    endfunction

    function automatic logic [31:0] expect_word(input logic [31:0] d, input logic [5:0] b);
        logic [63:0] m;
        m = (64'd1 << norm_len(b)) - 64'd1;
        return d & m[31:0];
    endfunction

    // One transfer on both instances; records what a passive observer sees each cycle
    task automatic do_xfer(input logic [31:0] d, input logic [5:0] b, input logic [1:0] s);
        logic p0, p3;
        int n3;
        m_cap0 = '0; m_cap3 = '0; m_edges0 = 0; m_edges3 = 0; m_low = 0;
        m_done_k = -1; m_ready_k = -1; m_done_cnt = 0; m_stray = 1'b0; n3 = 0;
        p0 = sclk0; p3 = sclk3;
        tx_data = d; tx_bits = b; tx_cs_sel = s; tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0; tx_data = ~d; tx_bits = 6'($urandom); tx_cs_sel = 2'($urandom);
        for (int k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            if (sclk0 !== p0) begin
                m_edges0++;
                if (sclk0 === 1'b1 && csn0[s] === 1'b0) m_cap0 = {m_cap0[30:0], mosi0};
            end
            if (sclk3 !== p3) begin
                m_edges3++;
                if (sclk3 === 1'b1 && csn3[s] === 1'b0 && n3 < 32) begin
                    m_cap3[n3] = mosi3;
                    n3++;
                end
            end
            p0 = sclk0; p3 = sclk3;
            if (csn0[s] === 1'b0) m_low++;
            if ((csn0 | (3'b001 << s)) !== 3'b111 || csn3 !== csn0 ||
                done3 !== done0 || ready3 !== ready0 || err0 !== 1'b0) m_stray = 1'b1;
            if (done0 === 1'b1) begin
                m_done_cnt++;
                m_done_k = k;
            end
            if (ready0 === 1'b1) begin
                m_ready_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ready0 !== 1'b1 || ready3 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b/%b expected 1/1", ready0, ready3); end
        checks++; if (done0 !== 1'b0 || err0 !== 1'b0 || done3 !== 1'b0 || err3 !== 1'b0) begin errors++; $display("FAIL reset_pulses: done %b/%b err %b/%b expected 0", done0, done3, err0, err3); end
        checks++; if (sclk0 !== 1'b0 || sclk3 !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b/%b expected 0/1", sclk0, sclk3); end
        checks++; if (csn0 !== 3'b111 || csn3 !== 3'b111 || mosi0 !== 1'b0 || mosi3 !== 1'b0) begin errors++; $display("FAIL reset_cs_mosi: cs %b/%b mosi %b/%b expected 111 and 0", csn0, csn3, mosi0, mosi3); end
`ifdef SPI_ATTN_READBACK_EN
        checks++; if (rx0 !== 32'd0 || rx3 !== 32'd0) begin errors++; $display("FAIL reset_rx: got %h/%h expected 0", rx0, rx3); end
`endif
        rst = 1'b0;
        @(negedge clk);
        $display("reset: ready=%b sclk=%b/%b cs=%b", ready0, sclk0, sclk3, csn0);
    endtask

    task automatic test_mode0;
        logic [31:0] d;
        int n;
        d = 32'h00A5C3F0;
        n = 24;
        checks++; if (sclk0 !== 1'b0 || sclk3 !== 1'b1) begin errors++; $display("FAIL mode_idle_before: got %b/%b expected 0/1", sclk0, sclk3); end
        do_xfer(d, 6'd24, 2'd2);
        $display("mode0/3 word=%h cap0=%h cap3=%h low=%0d done_k=%0d ready_k=%0d", d, m_cap0, m_cap3, m_low, m_done_k, m_ready_k);
        checks++; if (m_cap0 !== 32'h00A5C3F0) begin errors++; $display("FAIL mode0_mosi: got %h expected %h", m_cap0, 32'h00A5C3F0); end
        checks++; if (m_cap3 !== 32'h00A5C3F0) begin errors++; $display("FAIL mode3_lsb_mosi: got %h expected %h", m_cap3, 32'h00A5C3F0); end
        checks++; if (m_low !== (2 * n + 2) * H) begin errors++; $display("FAIL mode0_cs_low: got %0d expected %0d", m_low, (2 * n + 2) * H); end
        checks++; if (m_done_k !== 1 + (2 * n + 2) * H || m_done_cnt !== 1) begin errors++; $display("FAIL mode0_done: at %0d count %0d expected at %0d count 1", m_done_k, m_done_cnt, 1 + (2 * n + 2) * H); end
        checks++; if (m_ready_k !== 1 + (2 * n + 3) * H) begin errors++; $display("FAIL mode0_ready: got %0d expected %0d", m_ready_k, 1 + (2 * n + 3) * H); end
        checks++; if (m_stray !== 1'b0) begin errors++; $display("FAIL mode0_other_cs: got %b expected 0", m_stray); end
        checks++; if (m_edges0 !== 2 * n || m_edges3 !== 2 * n) begin errors++; $display("FAIL mode_edges: got %0d/%0d expected %0d", m_edges0, m_edges3, 2 * n); end
        checks++; if (sclk0 !== 1'b0 || sclk3 !== 1'b1) begin errors++; $display("FAIL mode_idle_after: got %b/%b expected 0/1", sclk0, sclk3); end
`ifdef SPI_ATTN_READBACK_EN
        checks++; if (rx0 !== 32'h00A5C3F0 || rx3 !== 32'h00A5C3F0) begin errors++; $display("FAIL mode_readback: got %h/%h expected %h", rx0, rx3, 32'h00A5C3F0); end
`endif
    endtask

    task automatic test_lengths;
        logic [5:0]  lens [2];
        logic [31:0] d;
        lens[0] = 6'd0;
        lens[1] = 6'd40;
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            do_xfer(d, lens[i], 2'd1);
            $display("length bits=%0d word=%h cap0=%h cap3=%h edges=%0d/%0d", lens[i], d, m_cap0, m_cap3, m_edges0, m_edges3);
            checks++; if (m_edges0 !== 64 || m_edges3 !== 64) begin errors++; $display("FAIL len_edges: got %0d/%0d expected 64", m_edges0, m_edges3); end
            checks++; if (m_cap0 !== d || m_cap3 !== d) begin errors++; $display("FAIL len_data: got %h/%h expected %h", m_cap0, m_cap3, d); end
            checks++; if (m_ready_k !== 1 + (2 * 32 + 3) * H) begin errors++; $display("FAIL len_ready: got %0d expected %0d", m_ready_k, 1 + (2 * 32 + 3) * H); end
        end
    endtask

    task automatic test_bad_sel;
        int errs0, errs3, err_k, busy, act;
        logic [31:0] d;
        errs0 = 0; errs3 = 0; err_k = -1; busy = 0; act = 0;
        tx_data = $urandom; tx_bits = 6'd8; tx_cs_sel = 2'd3; tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (err0 === 1'b1) begin errs0++; if (err_k < 0) err_k = k; end
            if (err3 === 1'b1) errs3++;
            if (ready0 !== 1'b1 || ready3 !== 1'b1) busy++;
            if (csn0 !== 3'b111 || csn3 !== 3'b111 || sclk0 !== 1'b0 || sclk3 !== 1'b1 || done0 !== 1'b0) act++;
        end
        $display("bad_sel sel=3 err=%0d/%0d at %0d busy=%0d activity=%0d", errs0, errs3, err_k, busy, act);
        checks++; if (errs0 !== 1 || errs3 !== 1 || err_k !== 0) begin errors++; $display("FAIL badsel_err: count %0d/%0d at %0d expected 1 at 0", errs0, errs3, err_k); end
        checks++; if (busy !== 0) begin errors++; $display("FAIL badsel_ready: busy cycles %0d expected 0", busy); end
        checks++; if (act !== 0) begin errors++; $display("FAIL badsel_activity: cycles %0d expected 0", act); end
        d = $urandom;
        do_xfer(d, 6'd16, 2'd0);
        $display("after bad_sel word=%h cap0=%h done=%0d", d, m_cap0, m_done_cnt);
        checks++; if (m_cap0 !== expect_word(d, 6'd16) || m_done_cnt !== 1) begin errors++; $display("FAIL badsel_next: got %h done %0d expected %h done 1", m_cap0, m_done_cnt, expect_word(d, 6'd16)); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d1, d2, cap2;
        int rise_k, acc2_k, gap, dones, n;
        bit done_seen, low2;
        logic p0;
        d1 = $urandom; d2 = $urandom; n = 8;
        rise_k = -1; acc2_k = -1; gap = 0; dones = 0; done_seen = 0; low2 = 0; cap2 = '0;
        p0 = sclk0;
        tx_data = d1; tx_bits = 6'(n); tx_cs_sel = 2'd0; tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_data = d2; tx_cs_sel = 2'd1;
        for (int k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            if (rise_k < 0 && ready0 === 1'b1) rise_k = k;
            else if (rise_k >= 0 && acc2_k < 0 && ready0 === 1'b0) begin
                acc2_k = k;
                tx_valid = 1'b0;
            end
            if (done_seen && !low2 && csn0 === 3'b111) gap++;
            if (csn0[1] === 1'b0) low2 = 1'b1;
            if (done0 === 1'b1) begin dones++; done_seen = 1'b1; end
            if (sclk0 !== p0 && sclk0 === 1'b1 && csn0[1] === 1'b0) cap2 = {cap2[30:0], mosi0};
            p0 = sclk0;
            if (dones == 2 && ready0 === 1'b1) break;
        end
        tx_valid = 1'b0;
        $display("back_to_back rise=%0d accept2=%0d gap=%0d dones=%0d cap2=%h", rise_k, acc2_k, gap, dones, cap2);
        checks++; if (rise_k !== 1 + (2 * n + 3) * H) begin errors++; $display("FAIL b2b_rise: got %0d expected %0d", rise_k, 1 + (2 * n + 3) * H); end
        checks++; if (acc2_k !== rise_k + 1) begin errors++; $display("FAIL b2b_accept: got %0d expected %0d", acc2_k, rise_k + 1); end
        checks++; if (gap < H) begin errors++; $display("FAIL b2b_gap: got %0d expected >= %0d", gap, H); end
        checks++; if (dones !== 2 || cap2 !== expect_word(d2, 6'(n))) begin errors++; $display("FAIL b2b_second: dones %0d data %h expected 2 and %h", dones, cap2, expect_word(d2, 6'(n))); end
    endtask

    task automatic test_random;
        logic [31:0] d, e;
        logic [5:0]  b;
        logic [1:0]  s;
        int n;
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            b = 6'($urandom_range(40, 0));
            s = 2'($urandom_range(2, 0));
            n = norm_len(b);
            e = expect_word(d, b);
            do_xfer(d, b, s);
            $display("random %0d word=%h bits=%0d sel=%0d cap0=%h cap3=%h done_k=%0d", i, d, b, s, m_cap0, m_cap3, m_done_k);
            checks++; if (m_cap0 !== e || m_cap3 !== e) begin errors++; $display("FAIL rnd_data: got %h/%h expected %h", m_cap0, m_cap3, e); end
            checks++; if (m_edges0 !== 2 * n) begin errors++; $display("FAIL rnd_edges: got %0d expected %0d", m_edges0, 2 * n); end
            checks++; if (m_done_k !== 1 + (2 * n + 2) * H || m_done_cnt !== 1) begin errors++; $display("FAIL rnd_done: at %0d count %0d expected at %0d", m_done_k, m_done_cnt, 1 + (2 * n + 2) * H); end
            checks++; if (m_ready_k !== 1 + (2 * n + 3) * H) begin errors++; $display("FAIL rnd_ready: got %0d expected %0d", m_ready_k, 1 + (2 * n + 3) * H); end
            checks++; if (m_stray !== 1'b0) begin errors++; $display("FAIL rnd_stray: got %b expected 0", m_stray); end
`ifdef SPI_ATTN_READBACK_EN
            checks++; if (rx0 !== e || rx3 !== e) begin errors++; $display("FAIL rnd_readback: got %h/%h expected %h", rx0, rx3, e); end
`endif
        end
    endtask

    task automatic test_reset_mid;
        int edges, dones;
        bit hit;
        logic p0;
        edges = 0; dones = 0; hit = 1'b0;
        p0 = sclk0;
        tx_data = $urandom; tx_bits = 6'd32; tx_cs_sel = 2'd1; tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (int k = 0; k < LIMIT && !hit; k++) begin
            @(negedge clk);
            if (sclk0 !== p0) edges++;
            p0 = sclk0;
            if (edges == 10) hit = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        $display("reset_mid edges=%0d cs=%b/%b sclk=%b/%b ready=%b", edges, csn0, csn3, sclk0, sclk3, ready0);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rmid_reach: edges %0d expected 10", edges); end
        checks++; if (csn0 !== 3'b111 || csn3 !== 3'b111) begin errors++; $display("FAIL rmid_cs: got %b/%b expected 111", csn0, csn3); end
        checks++; if (sclk0 !== 1'b0 || sclk3 !== 1'b1) begin errors++; $display("FAIL rmid_sclk: got %b/%b expected 0/1", sclk0, sclk3); end
        checks++; if (ready0 !== 1'b1 || ready3 !== 1'b1 || mosi0 !== 1'b0) begin errors++; $display("FAIL rmid_ready: ready %b/%b mosi %b expected 1/1 and 0", ready0, ready3, mosi0); end
        rst = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done0 === 1'b1 || done3 === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL rmid_done: got %0d pulses expected 0", dones); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_lengths();
        test_bad_sel();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
